// File: rtl/bsk_prm_pkg.sv
// Shared definitions for the BskPRM bus master.
// Holds the chip-select codes of the two PRM units, the register addresses,
// the key and password constants, the operation and state enums, and the
// complement-checked command encoding.
package bsk_prm_pkg;

  // Chip-select codes: unit 0 carries commands 1-16, unit 1 carries 17-32.
  localparam logic [3:0] CS_16_01 = 4'b0111;
  localparam logic [3:0] CS_32_17 = 4'b0101;
  localparam logic [3:0] CS_IDLE  = 4'b1111;

  // PRM register addresses (reads and writes share the 2-bit space).
  localparam logic [1:0] REG_COM_LO = 2'b00;
  localparam logic [1:0] REG_COM_HI = 2'b01;
  localparam logic [1:0] REG_IND    = 2'b10;
  localparam logic [1:0] REG_EN     = 2'b11;
  localparam logic [1:0] REG_TEST   = 2'b00;
  localparam logic [1:0] REG_ID     = 2'b11;

  localparam logic [7:0] PASSWORD = 8'hA6;
  localparam logic [7:0] EN_KEY   = 8'hE1;
  localparam logic [7:0] DIS_KEY  = 8'h11;

  typedef enum logic [2:0] {
    OP_WR_COM  = 3'd0,
    OP_WR_IND  = 3'd1,
    OP_WR_EN   = 3'd2,
    OP_RD_TEST = 3'd3,
    OP_RD_ID   = 3'd4
  } op_t;

  // Timing-engine phases.
  typedef enum logic [1:0] {
    CYC_IDLE   = 2'd0,
    CYC_SETUP  = 2'd1,
    CYC_STROBE = 2'd2,
    CYC_HOLD   = 2'd3
  } cycState_t;

  // Operation sequencer states; NEXT is the idle-bus gap between the two
  // halves of a command write.
  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_CYC1 = 3'd1,
    M_NEXT = 3'd2,
    M_CYC2 = 3'd3,
    M_DONE = 3'd4
  } mstState_t;

  // Each nibble is preceded by its complement so the PRM can reject
  // corrupted command words.
  function automatic logic [15:0] prm_enc(input logic [7:0] c);
    return {~c[7:4], c[7:4], ~c[3:0], c[3:0]};
  endfunction

endpackage

// File: rtl/bsk_bus_cycle.sv
// Single read/write bus cycle timing engine.
// iStart (accepted only when idle) loads address/CS/data and runs
// SETUP(T_SU) -> STROBE(T_STB) -> HOLD(T_HD); the bus is released when HOLD ends.
// Ports: iClk/iRes clock and async active-low reset; iStart/iRead/iAddr/iCs/iWData
// cycle request; iD read bus; oLast high in the final HOLD clock; oA/oCS/oWr/oRd/
// oD/oDOe registered bus drive; oRdData word sampled at the end of STROBE.
module bsk_bus_cycle
  import bsk_prm_pkg::*;
#(
  parameter int T_SU  = 2,
  parameter int T_STB = 4,
  parameter int T_HD  = 2
) (
  input  logic        iClk,
  input  logic        iRes,
  input  logic        iStart,
  input  logic        iRead,
  input  logic [1:0]  iAddr,
  input  logic [3:0]  iCs,
  input  logic [15:0] iWData,
  input  logic [15:0] iD,
  output logic        oLast,
  output logic [1:0]  oA,
  output logic [3:0]  oCS,
  output logic        oWr,
  output logic        oRd,
  output logic [15:0] oD,
  output logic        oDOe,
  output logic [15:0] oRdData
);

  localparam logic [7:0] SU_LAST  = 8'(T_SU - 1);
  localparam logic [7:0] STB_LAST = 8'(T_STB - 1);
  localparam logic [7:0] HD_LAST  = 8'(T_HD - 1);

  cycState_t   state_r, stateNext_s;
  logic [7:0]  cnt_r, cntNext_s;
  logic        read_r;
  logic        setupEnd_s, strobeEnd_s, holdEnd_s;

  // Phase sequencing and per-phase clock counting.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    setupEnd_s  = 1'b0;
    strobeEnd_s = 1'b0;
    holdEnd_s   = 1'b0;
    case (state_r)
      CYC_IDLE: begin
        if (iStart) begin
          stateNext_s = CYC_SETUP;
          cntNext_s   = 8'd0;
        end else begin
          stateNext_s = CYC_IDLE;
        end
      end
      CYC_SETUP: begin
        if (cnt_r == SU_LAST) begin
          setupEnd_s  = 1'b1;
          stateNext_s = CYC_STROBE;
          cntNext_s   = 8'd0;
        end else begin
          cntNext_s = cnt_r + 8'd1;
        end
      end
      CYC_STROBE: begin
        if (cnt_r == STB_LAST) begin
          strobeEnd_s = 1'b1;
          stateNext_s = CYC_HOLD;
          cntNext_s   = 8'd0;
        end else begin
          cntNext_s = cnt_r + 8'd1;
        end
      end
      CYC_HOLD: begin
        if (cnt_r == HD_LAST) begin
          holdEnd_s   = 1'b1;
          stateNext_s = CYC_IDLE;
          cntNext_s   = 8'd0;
        end else begin
          cntNext_s = cnt_r + 8'd1;
        end
      end
      default: begin
        stateNext_s = CYC_IDLE;
        cntNext_s   = 8'd0;
      end
    endcase
  end

  assign oLast = holdEnd_s;

  // Phase and counter registers.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      state_r <= CYC_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Registered bus drive; the strobe falls only after SETUP, so oDOe is
  // never high together with oRd low because reads never raise oDOe.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      oA      <= 2'b00;
      oCS     <= CS_IDLE;
      oWr     <= 1'b1;
      oRd     <= 1'b1;
      oD      <= 16'h0000;
      oDOe    <= 1'b0;
      oRdData <= 16'h0000;
      read_r  <= 1'b0;
    end else begin
      if ((state_r == CYC_IDLE) && iStart) begin
        oA     <= iAddr;
        oCS    <= iCs;
        oD     <= iWData;
        oDOe   <= ~iRead;
        read_r <= iRead;
      end
      if (setupEnd_s) begin
        oWr <= read_r;
        oRd <= ~read_r;
      end
      if (strobeEnd_s) begin
        oWr <= 1'b1;
        oRd <= 1'b1;
        if (read_r) begin
          oRdData <= iD;
        end
      end
      if (holdEnd_s) begin
        oCS  <= CS_IDLE;
        oDOe <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bsk_prm_master.sv
// Clocked bus master for the BskPRM register bus.
// Turns one request (iReq/iOp/iUnit/iData) into a complete, timed bus sequence:
// command write (two encoded bytes), indication write, enable write, test read
// or ID read with password check.
// Ports: iClk/iRes clock and async active-low reset; iReq/iOp/iUnit/iData request;
// oBusy/oDone/oErr status; oRdData last read word; oA/oCS/oWr/oRd/oD/oDOe bus
// drive; iD bus read-back.
module bsk_prm_master
  import bsk_prm_pkg::*;
#(
  parameter int T_SU  = 2,
  parameter int T_STB = 4,
  parameter int T_HD  = 2
) (
  input  logic        iClk,
  input  logic        iRes,
  input  logic        iReq,
  input  logic [2:0]  iOp,
  input  logic        iUnit,
  input  logic [15:0] iData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr,
  output logic [15:0] oRdData,
  output logic [1:0]  oA,
  output logic [3:0]  oCS,
  output logic        oWr,
  output logic        oRd,
  output logic [15:0] oD,
  output logic        oDOe,
  input  logic [15:0] iD
);

  mstState_t   state_r, stateNext_s;
  logic [2:0]  op_r, selOp_s;
  logic        unit_r, selUnit_s;
  logic [15:0] data_r, selData_s;
  logic        start_s, errNext_s, legal_s;
  logic        cycRead_s, cycLast_s;
  logic [1:0]  cycAddr_s;
  logic [3:0]  cycCs_s;
  logic [15:0] cycWData_s;

  // Cycle parameters come straight from the request pins in IDLE so the bus
  // is set up on the very clock that accepts the request.
  always_comb begin
    if (state_r == M_IDLE) begin
      selOp_s   = iOp;
      selUnit_s = iUnit;
      selData_s = iData;
    end else begin
      selOp_s   = op_r;
      selUnit_s = unit_r;
      selData_s = data_r;
    end
    cycCs_s    = selUnit_s ? CS_32_17 : CS_16_01;
    cycAddr_s  = 2'b00;
    cycWData_s = 16'h0000;
    cycRead_s  = 1'b0;
    case (selOp_s)
      OP_WR_COM: begin
        if (state_r == M_NEXT) begin
          cycAddr_s  = REG_COM_HI;
          cycWData_s = prm_enc(selData_s[15:8]);
        end else begin
          cycAddr_s  = REG_COM_LO;
          cycWData_s = prm_enc(selData_s[7:0]);
        end
      end
      OP_WR_IND: begin
        cycAddr_s  = REG_IND;
        cycWData_s = selData_s;
      end
      OP_WR_EN: begin
        cycAddr_s  = REG_EN;
        cycWData_s = selData_s[0] ? {8'h00, EN_KEY} : {8'h00, DIS_KEY};
      end
      OP_RD_TEST: begin
        cycAddr_s = REG_TEST;
        cycRead_s = 1'b1;
      end
      OP_RD_ID: begin
        cycAddr_s = REG_ID;
        cycRead_s = 1'b1;
      end
      default: begin
        cycAddr_s = 2'b00;
        cycRead_s = 1'b0;
      end
    endcase
  end

  assign legal_s = (iOp <= OP_RD_ID);

  // Operation sequencing: next state, cycle start and error verdict.
  always_comb begin
    stateNext_s = state_r;
    start_s     = 1'b0;
    errNext_s   = 1'b0;
    case (state_r)
      M_IDLE: begin
        if (iReq) begin
          if (legal_s) begin
            start_s     = 1'b1;
            stateNext_s = M_CYC1;
          end else begin
            stateNext_s = M_DONE;
            errNext_s   = 1'b1;
          end
        end else begin
          stateNext_s = M_IDLE;
        end
      end
      M_CYC1: begin
        if (cycLast_s) begin
          if (op_r == OP_WR_COM) begin
            stateNext_s = M_NEXT;
          end else begin
            stateNext_s = M_DONE;
            // The ID word was sampled at the end of STROBE, two clocks ago.
            errNext_s   = (op_r == OP_RD_ID) &&
                          ((oRdData[15:8] != PASSWORD) || !oRdData[1]);
          end
        end else begin
          stateNext_s = M_CYC1;
        end
      end
      M_NEXT: begin
        start_s     = 1'b1;
        stateNext_s = M_CYC2;
      end
      M_CYC2: begin
        if (cycLast_s) begin
          stateNext_s = M_DONE;
        end else begin
          stateNext_s = M_CYC2;
        end
      end
      M_DONE: begin
        stateNext_s = M_IDLE;
      end
      default: begin
        stateNext_s = M_IDLE;
      end
    endcase
  end

  // Sequencer state, request latch and registered status outputs.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      state_r <= M_IDLE;
      op_r    <= 3'd0;
      unit_r  <= 1'b0;
      data_r  <= 16'h0000;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oErr    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      if ((state_r == M_IDLE) && iReq) begin
        op_r   <= iOp;
        unit_r <= iUnit;
        data_r <= iData;
      end
      oBusy <= (stateNext_s == M_CYC1) || (stateNext_s == M_NEXT) ||
               (stateNext_s == M_CYC2);
      oDone <= (stateNext_s == M_DONE);
      oErr  <= errNext_s;
    end
  end

  bsk_bus_cycle #(
    .T_SU  (T_SU),
    .T_STB (T_STB),
    .T_HD  (T_HD)
  ) uCycle (
    .iClk    (iClk),
    .iRes    (iRes),
    .iStart  (start_s),
    .iRead   (cycRead_s),
    .iAddr   (cycAddr_s),
    .iCs     (cycCs_s),
    .iWData  (cycWData_s),
    .iD      (iD),
    .oLast   (cycLast_s),
    .oA      (oA),
    .oCS     (oCS),
    .oWr     (oWr),
    .oRd     (oRd),
    .oD      (oD),
    .oDOe    (oDOe),
    .oRdData (oRdData)
  );

endmodule

// File: tb/tb_bsk_prm_master.sv
// Self-checking bench for bsk_prm_master. A behavioural PRM model watches the
// bus (writes captured on the rising write strobe, reads on the rising read
// strobe) and answers reads; expectations come from the operation rules.
module tb_bsk_prm_master;

  logic        iClk = 1'b0;
  logic        iRes;
  logic        iReq;
  logic [2:0]  iOp;
  logic        iUnit;
  logic [15:0] iData;
  logic        oBusy, oDone, oErr;
  logic [15:0] oRdData;
  logic [1:0]  oA;
  logic [3:0]  oCS;
  logic        oWr, oRd;
  logic [15:0] oD;
  logic        oDOe;
  logic [15:0] iD;

  logic [15:0] idWord   = 16'hA6C6;
  logic [15:0] testWord = 16'h0000;

  int cmpCnt = 0;
  int failCnt = 0;

  logic [21:0] wrQ[$];
  logic [5:0]  rdQ[$];
  int wrLowCnt = 0;
  int doneCnt = 0;
  int doeViol = 0;
  int csActCnt = 0;

  // PRM model state per unit
  logic [15:0] prmCmd[2];
  logic [15:0] prmInd[2];
  logic        prmEn[2];

  always #5 iClk = ~iClk;

  bsk_prm_master dut (
    .iClk(iClk), .iRes(iRes), .iReq(iReq), .iOp(iOp), .iUnit(iUnit), .iData(iData),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oRdData(oRdData),
    .oA(oA), .oCS(oCS), .oWr(oWr), .oRd(oRd), .oD(oD), .oDOe(oDOe), .iD(iD)
  );

  assign iD = (oA == 2'b11) ? idWord : testWord;

  function automatic logic [15:0] refEnc(input logic [7:0] c);
    int hi, lo;
    hi = int'(c) / 16;
    lo = int'(c) % 16;
    return 16'(((15 - hi) * 4096) + (hi * 256) + ((15 - lo) * 16) + lo);
  endfunction

  function automatic logic [3:0] csOf(input logic u);
    return u ? 4'b0101 : 4'b0111;
  endfunction

  // Write side of the PRM model
  always @(posedge oWr) begin
    if (iRes === 1'b1) begin
      int u;
      wrQ.push_back({oCS, oA, oD});
      u = (oCS == 4'b0101) ? 1 : 0;
      case (oA)
        2'b00: if ((oD[15:12] == ~oD[11:8]) && (oD[7:4] == ~oD[3:0])) prmCmd[u][7:0] = {oD[11:8], oD[3:0]};
        2'b01: if ((oD[15:12] == ~oD[11:8]) && (oD[7:4] == ~oD[3:0])) prmCmd[u][15:8] = {oD[11:8], oD[3:0]};
        2'b10: prmInd[u] = ~oD;
        default: begin
          if (oD == 16'h00E1) prmEn[u] = 1'b0;
          else if (oD == 16'h0011) prmEn[u] = 1'b1;
        end
      endcase
    end
  end

  always @(posedge oRd) begin
    if (iRes === 1'b1) rdQ.push_back({oCS, oA});
  end

  always @(negedge iClk) begin
    if (oWr === 1'b0) wrLowCnt++;
    if (oDone === 1'b1) doneCnt++;
    if ((oRd === 1'b0) && (oDOe === 1'b1)) doeViol++;
    if (oCS !== 4'b1111) csActCnt++;
  end

  task automatic run_op(input logic [2:0] op, input logic u, input logic [15:0] d,
                        output int lat, output logic err);
    wrQ.delete();
    rdQ.delete();
    @(negedge iClk);
    wrLowCnt = 0;
    csActCnt = 0;
    iOp = op; iUnit = u; iData = d; iReq = 1'b1;
    lat = 0;
    do begin
      @(posedge iClk);
      #1;
      iReq = 1'b0;
      iData = 16'($urandom);
      lat++;
    end while ((oDone !== 1'b1) && (lat < 200));
    err = oErr;
    if (oDone !== 1'b1) begin
      cmpCnt++; failCnt++;
      $display("FAIL done_timeout op=%0d got no oDone within %0d clocks", op, lat);
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    got = {oWr, oRd, oCS, oA, oD, oDOe, oBusy, oDone, oErr, oRdData[1:0]};
    cmpCnt++;
    if (got !== {1'b1, 1'b1, 4'b1111, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00} || oRdData !== 16'h0000) begin
      failCnt++;
      $display("FAIL reset_state got %h rd=%h required %h rd=0000", got, oRdData,
               {1'b1, 1'b1, 4'b1111, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    end
  endtask

  task automatic test_wr_com();
    int lat; logic err; logic [15:0] d; logic u;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 16'h085A : 16'($urandom);
      u = (k == 0) ? 1'b0 : 1'($urandom);
      run_op(3'd0, u, d, lat, err);
      cmpCnt++;
      if (lat !== 18 || err !== 1'b0) begin
        failCnt++; $display("FAIL wrcom_latency got lat=%0d err=%b required lat=18 err=0", lat, err);
      end
      cmpCnt++;
      if (wrQ.size() != 2) begin
        failCnt++; $display("FAIL wrcom_count got %0d writes required 2", wrQ.size());
      end else begin
        cmpCnt++;
        if (wrQ[0] !== {csOf(u), 2'b00, refEnc(d[7:0])} || wrQ[1] !== {csOf(u), 2'b01, refEnc(d[15:8])}) begin
          failCnt++;
          $display("FAIL wrcom_words got %h %h required %h %h", wrQ[0], wrQ[1],
                   {csOf(u), 2'b00, refEnc(d[7:0])}, {csOf(u), 2'b01, refEnc(d[15:8])});
        end
      end
      cmpCnt++;
      if (wrLowCnt != 8) begin
        failCnt++; $display("FAIL wrcom_strobe got %0d low clocks required 8", wrLowCnt);
      end
      if (k == 0) begin
        cmpCnt++;
        if (wrQ.size() != 2 || wrQ[0][15:0] !== 16'hA55A || wrQ[1][15:0] !== 16'hF078 || ~prmCmd[0] !== 16'hF7A5) begin
          failCnt++; $display("FAIL wrcom_directed got prm oCom=%h required F7A5 (words A55A F078)", ~prmCmd[0]);
        end
      end
    end
  endtask

  task automatic test_wr_ind();
    int lat; logic err; logic [15:0] d; logic u;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 16'h1234 : 16'($urandom);
      u = (k == 0) ? 1'b0 : 1'($urandom);
      run_op(3'd1, u, d, lat, err);
      cmpCnt++;
      if (lat !== 9 || err !== 1'b0 || wrLowCnt != 4) begin
        failCnt++; $display("FAIL wrind_timing got lat=%0d err=%b low=%0d required 9 0 4", lat, err, wrLowCnt);
      end
      cmpCnt++;
      if (wrQ.size() != 1 || wrQ[0] !== {csOf(u), 2'b10, d}) begin
        failCnt++; $display("FAIL wrind_word got n=%0d required %h", wrQ.size(), {csOf(u), 2'b10, d});
      end
      if (k == 0) begin
        cmpCnt++;
        if (prmInd[0] !== 16'hEDCB) begin
          failCnt++; $display("FAIL wrind_prm got %h required EDCB", prmInd[0]);
        end
      end
    end
  endtask

  task automatic test_wr_en();
    int lat; logic err; logic [15:0] d;
    for (int k = 0; k < 2; k++) begin
      d = 16'($urandom);
      d[0] = (k == 0) ? 1'b1 : 1'b0;
      run_op(3'd2, 1'b1, d, lat, err);
      cmpCnt++;
      if (lat !== 9 || wrQ.size() != 1 || wrQ[0] !== {4'b0101, 2'b11, (k == 0) ? 16'h00E1 : 16'h0011}) begin
        failCnt++; $display("FAIL wren_word k=%0d got lat=%0d n=%0d required lat=9 one write", k, lat, wrQ.size());
      end
      cmpCnt++;
      if (prmEn[1] !== ((k == 0) ? 1'b0 : 1'b1)) begin
        failCnt++; $display("FAIL wren_prm k=%0d got oEnable=%b required %b", k, prmEn[1], (k == 0) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_rd_test();
    int lat; logic err; logic u; logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      testWord = w;
      u = 1'($urandom);
      run_op(3'd3, u, 16'($urandom), lat, err);
      testWord = ~w;
      cmpCnt++;
      if (lat !== 9 || err !== 1'b0 || oRdData !== w) begin
        failCnt++; $display("FAIL rdtest_data got lat=%0d err=%b rd=%h required 9 0 %h", lat, err, oRdData, w);
      end
      cmpCnt++;
      if (rdQ.size() != 1 || rdQ[0] !== {csOf(u), 2'b00} || wrQ.size() != 0) begin
        failCnt++; $display("FAIL rdtest_bus got reads=%0d writes=%0d required 1 0", rdQ.size(), wrQ.size());
      end
    end
  endtask

  task automatic test_rd_id();
    int lat; logic err; logic expErr; logic [15:0] w;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: w = 16'hA6C6;
        1: w = 16'h00C6;
        2: w = 16'hA6C4;
        default: begin
          w = 16'($urandom);
          if ($urandom_range(0, 1) == 0) w[15:8] = 8'hA6;
        end
      endcase
      idWord = w;
      expErr = ((w / 256) != 166) || (((w / 2) % 2) == 0);
      run_op(3'd4, 1'($urandom), 16'($urandom), lat, err);
      cmpCnt++;
      if (lat !== 9 || oRdData !== w || err !== expErr) begin
        failCnt++; $display("FAIL rdid k=%0d got lat=%0d rd=%h err=%b required 9 %h %b", k, lat, oRdData, err, w, expErr);
      end
      cmpCnt++;
      if (rdQ.size() != 1 || rdQ[0][1:0] !== 2'b11) begin
        failCnt++; $display("FAIL rdid_addr got reads=%0d required 1 at A=11", rdQ.size());
      end
    end
    idWord = 16'hA6C6;
    cmpCnt++;
    if (doeViol != 0) begin
      failCnt++; $display("FAIL doe_during_read got %0d clocks required 0", doeViol);
    end
  endtask

  task automatic test_illegal();
    int lat; logic err;
    for (int op = 5; op < 8; op++) begin
      run_op(3'(op), 1'($urandom), 16'($urandom), lat, err);
      cmpCnt++;
      if (lat !== 1 || err !== 1'b1 || wrQ.size() != 0 || rdQ.size() != 0 || csActCnt != 0) begin
        failCnt++; $display("FAIL illegal op=%0d got lat=%0d err=%b wr=%0d rd=%0d cs=%0d required 1 1 0 0 0",
                            op, lat, err, wrQ.size(), rdQ.size(), csActCnt);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int d0;
    wrQ.delete(); rdQ.delete();
    d0 = doneCnt;
    @(negedge iClk);
    iOp = 3'd1; iUnit = 1'b0; iData = 16'($urandom); iReq = 1'b1;
    @(posedge iClk); #1; iReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk); iReq = 1'b1; iOp = 3'd3;
      @(negedge iClk); iReq = 1'b0;
    end
    repeat (25) @(negedge iClk);
    cmpCnt++;
    if ((doneCnt - d0) != 1 || wrQ.size() != 1 || rdQ.size() != 0) begin
      failCnt++; $display("FAIL busy_ignore got done=%0d wr=%0d rd=%0d required 1 1 0", doneCnt - d0, wrQ.size(), rdQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0; logic [15:0] d; logic u; int bad;
    wrQ.delete(); rdQ.delete();
    d0 = doneCnt;
    d = 16'($urandom); u = 1'($urandom);
    @(negedge iClk);
    iOp = 3'd1; iUnit = u; iData = d; iReq = 1'b1;
    @(posedge iClk);
    repeat (24) @(posedge iClk);
    #1; iReq = 1'b0;
    repeat (20) @(negedge iClk);
    bad = 0;
    foreach (wrQ[i]) if (wrQ[i] !== {csOf(u), 2'b10, d}) bad++;
    cmpCnt++;
    if ((doneCnt - d0) != 3 || wrQ.size() != 3 || bad != 0) begin
      failCnt++; $display("FAIL back_to_back got done=%0d wr=%0d bad=%0d required 3 3 0", doneCnt - d0, wrQ.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    int n; int d0;
    wrQ.delete(); rdQ.delete();
    d0 = doneCnt;
    @(negedge iClk);
    iOp = 3'd0; iUnit = 1'b0; iData = 16'($urandom); iReq = 1'b1;
    @(posedge iClk); #1; iReq = 1'b0;
    n = 0;
    while (oWr !== 1'b0 && n < 50) begin
      @(negedge iClk); n++;
    end
    cmpCnt++;
    if (oWr !== 1'b0) begin
      failCnt++; $display("FAIL rstmid_strobe got oWr=%b required 0 before reset", oWr);
    end
    iRes = 1'b0;
    #1;
    cmpCnt++;
    if (oWr !== 1'b1 || oCS !== 4'b1111 || oBusy !== 1'b0) begin
      failCnt++; $display("FAIL rstmid_release got oWr=%b oCS=%b busy=%b required 1 1111 0", oWr, oCS, oBusy);
    end
    @(negedge iClk); iRes = 1'b1;
    repeat (40) @(negedge iClk);
    cmpCnt++;
    if (wrQ.size() != 0 || (doneCnt - d0) != 0) begin
      failCnt++; $display("FAIL rstmid_abandon got wr=%0d done=%0d required 0 0", wrQ.size(), doneCnt - d0);
    end
  endtask

  initial begin
    iRes = 1'b0; iReq = 1'b0; iOp = 3'd0; iUnit = 1'b0; iData = 16'h0000;
    prmCmd[0] = 16'h0000; prmCmd[1] = 16'h0000;
    prmInd[0] = 16'h0000; prmInd[1] = 16'h0000;
    prmEn[0] = 1'b1; prmEn[1] = 1'b1;
    repeat (3) @(negedge iClk);
    test_reset();
    iRes = 1'b1;
    repeat (2) @(negedge iClk);
    test_wr_com();
    test_wr_ind();
    test_wr_en();
    test_rd_test();
    test_rd_id();
    test_illegal();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
    $finish;
  end

endmodule
